coin_frontend: RTL and testbench
================================

# coin_frontend

Input conditioning stage that sits directly upstream of the vending-machine DFA. It takes the three raw mechanical coin-sensor lines and synchronises and debounces each one. It turns every accepted coin into a single-cycle, strictly one-hot pulse on `in1`, `in2` or `in5`, which drive the DFA inputs of the same names. Coins landing together are queued, then serialised by priority with a programmable idle gap between pulses.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples needed to accept a level change; legal range 1..65535.
- `GAP_CYCLES`, 1: idle cycles forced after every emitted pulse; legal range 0..255.
- `clk`  in  1  system clock; all flops on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `raw_c1`  in  1  coin-1 sensor, asynchronous, active-high, may bounce.
- `raw_c2`  in  1  coin-2 sensor, same properties.
- `raw_c5`  in  1  coin-5 sensor, same properties.
- `in1`  out  1  one-cycle pulse: one coin of value 1 accepted.
- `in2`  out  1  one-cycle pulse: one coin of value 2 accepted.
- `in5`  out  1  one-cycle pulse: one coin of value 5 accepted.
- `coin_lost`  out  1  one-cycle pulse: an accepted coin was dropped because its pending slot was full.

## Operation
- **Reset state.** While `rst_n`=0:
  - all outputs are 0;
  - synchroniser flops, stable levels, counters and pending bits are 0;
  - the arbiter is in IDLE.
  - A sensor already held high at reset release is therefore accepted as a coin once it has been debounced.
- **Synchroniser.** Each raw line passes through a 2-flop synchroniser.
- **Debounce, per channel.** The channel keeps a stable level and a counter.
  - If the synchronised value equals the stable level, the counter clears.
  - Otherwise the counter increments.
  - On the edge where a mismatch is seen with counter = `DEBOUNCE_CYCLES`-1, the stable level flips and the counter clears.
  - A mismatch shorter than `DEBOUNCE_CYCLES` samples is ignored entirely.
- **Acceptance.**
  - A 0->1 flip of the stable level sets that channel's pending bit on the same edge.
  - A 1->0 flip has no effect.
  - If the pending bit is already 1 and is not being cleared on that edge, `coin_lost` pulses and the pending bit stays 1.
  - If the arbiter clears the bit on the same edge as a new set, the set wins: the bit stays 1 and no loss is reported.
- **Arbiter FSM** (encoding in the shared include):
  - IDLE, no pending bit set: all outputs 0.
  - IDLE, any pending bit set: register a pulse for the highest-priority pending channel (5 > 2 > 1) and clear that pending bit.
    - If `GAP_CYCLES`=0, stay in IDLE.
    - Otherwise go to GAP and load the gap counter with `GAP_CYCLES`.
  - GAP: outputs 0; decrement the counter each cycle; return to IDLE on the edge where it reaches 1.
- **Output guarantees.** `in1`/`in2`/`in5` are registered and are never high together. Each one is high for exactly one cycle per accepted coin.
- **Reset mid-operation.** Pending coins and any pulse in flight are discarded. No pulse is emitted during or immediately after reset.

## Timing
- Let edge E be the first edge at which `raw_cX`=1 is sampled, with the arbiter idle and the line held clean.
  - The stable level flips and the pending bit sets at edge E+1+`DEBOUNCE_CYCLES`.
  - The output pulse rises at edge E+2+`DEBOUNCE_CYCLES` and falls at the following edge.
- Back-to-back pending coins are emitted every `GAP_CYCLES`+1 cycles.
- Capacity is one outstanding coin per denomination; a second coin of the same value can be accepted only after its first pulse has been issued.
- The minimum spacing of distinct same-channel coins is bounded by 2×`DEBOUNCE_CYCLES` cycles, because the line must debounce low and then high again.

## Structure
- Shared include `coin_defs.vh` holds:
  - arbiter state encodings (IDLE=0, GAP=1);
  - channel indices (C1=0, C2=1, C5=2);
  - the priority order.
- Sub-module `coin_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `raw`, `rise`) contains the synchroniser, counter and stable level, and is instantiated three times.
- The top level holds the pending bits, loss detection, arbiter FSM and output registers.
- Counter widths are derived with `$clog2` from the parameters.

## Test plan
- **Single clean coin.** `DEBOUNCE_CYCLES`=16; `raw_c2` held high from edge 10 -> `in2` high only in the cycle after edge 28; `in1`, `in5` and `coin_lost` stay 0 throughout.
- **Bounce rejection.** `raw_c1` toggles every 5 cycles for 100 cycles, then stays high -> no pulse during toggling; exactly one `in1` pulse 18 edges after the final rise is first sampled.
- **Simultaneous coins.** All three raw lines rise at the same edge, `GAP_CYCLES`=1 -> pulses in the order `in5`, `in2`, `in1`, on edges 18, 20 and 22 after E; never two outputs high together.
- **Overflow.** Force the arbiter into a long GAP (`GAP_CYCLES`=200); accept two 5-coins during the gap -> one `coin_lost` pulse; exactly one `in5` pulse afterwards.
- **Reset mid-operation.** Pending `in2` and `in1` present; pulse `rst_n` low for 3 cycles while all raw lines are low -> all outputs 0; no pulses after release.
- **Gap of zero.** `GAP_CYCLES`=0 with 1- and 2-coins pending -> `in2` and `in1` pulses on consecutive edges.

Source files
------------

// File: rtl/coin_frontend_pkg.sv
// Shared definitions for the coin front end: arbiter states, channel indices
// and the emission priority order.
package coin_frontend_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_GAP  = 1'b1
   } arb_state_t;

   localparam int NUM_CH = 3;
   localparam int C1     = 0;
   localparam int C2     = 1;
   localparam int C5     = 2;

   // Highest priority first.
   localparam int PRIO [NUM_CH] = '{C5, C2, C1};

   // One-hot grant of the highest-priority pending channel, or zero.
   function automatic logic [NUM_CH-1:0] pick_grant(input logic [NUM_CH-1:0] pend);
      logic [NUM_CH-1:0] g;
      g = '0;
      // Walk from lowest to highest priority so the last hit wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (pend[PRIO[k]]) begin
            g          = '0;
            g[PRIO[k]] = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser followed by a debouncer that flips
// its stable level after DEBOUNCE_CYCLES consecutive mismatching samples.
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             stable_reg;
   logic             stable_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      stable_next = stable_reg;
      cnt_next    = '0;
      if (sync2_reg != stable_reg) begin
         if (cnt_reg == CNT_LAST) begin
            stable_next = sync2_reg;
         end else begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end
   end

   // Combinational so the pending bit sets on the same edge as the flip.
   assign rise = sync2_reg & ~stable_reg & (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         sync1_reg  <= raw;
         sync2_reg  <= sync1_reg;
         stable_reg <= stable_next;
         cnt_reg    <= cnt_next;
      end
   end

endmodule

// File: rtl/coin_frontend.sv
// Coin sensor front end: debounces three coin lines, holds one pending coin per
// denomination and serialises them as one-hot single-cycle pulses with a gap.
module coin_frontend
   import coin_frontend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int GAP_CYCLES      = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_c1,
   input  logic raw_c2,
   input  logic raw_c5,
   output logic in1,
   output logic in2,
   output logic in5,
   output logic coin_lost
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   logic [NUM_CH-1:0] raw_vec;
   logic [NUM_CH-1:0] rise_vec;

   assign raw_vec[C1] = raw_c1;
   assign raw_vec[C2] = raw_c2;
   assign raw_vec[C5] = raw_c5;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_deb
         coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_vec[gi]),
            .rise (rise_vec[gi])
         );
      end
   endgenerate

   arb_state_t        state_reg;
   arb_state_t        state_next;
   logic [GAP_W-1:0]  gap_cnt_reg;
   logic [GAP_W-1:0]  gap_cnt_next;
   logic [NUM_CH-1:0] pend_reg;
   logic [NUM_CH-1:0] pend_next;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] lost;
   logic [NUM_CH-1:0] pulse_reg;
   logic              lost_reg;

   // Arbiter next state and gap counter.
   always_comb begin
      state_next   = state_reg;
      gap_cnt_next = gap_cnt_reg;
      case (state_reg)
         ARB_IDLE: begin
            if ((|pend_reg) && (GAP_CYCLES != 0)) begin
               state_next   = ARB_GAP;
               gap_cnt_next = GAP_W'(GAP_CYCLES);
            end
         end
         ARB_GAP: begin
            if (gap_cnt_reg == GAP_W'(1)) begin
               state_next   = ARB_IDLE;
               gap_cnt_next = '0;
            end else begin
               gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            end
         end
         default: begin
            state_next   = ARB_IDLE;
            gap_cnt_next = '0;
         end
      endcase
   end

   // Arbiter outputs: grant only while idle.
   always_comb begin
      grant = '0;
      if (state_reg == ARB_IDLE) begin
         grant = pick_grant(pend_reg);
      end
   end

   // A new acceptance beats a same-edge clear; a set onto a held bit is a loss.
   always_comb begin
      lost      = rise_vec & pend_reg & ~grant;
      pend_next = (pend_reg & ~grant) | rise_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ARB_IDLE;
         gap_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         gap_cnt_reg <= gap_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg  <= '0;
         pulse_reg <= '0;
         lost_reg  <= 1'b0;
      end else begin
         pend_reg  <= pend_next;
         pulse_reg <= grant;
         lost_reg  <= |lost;
      end
   end

   assign in1       = pulse_reg[C1];
   assign in2       = pulse_reg[C2];
   assign in5       = pulse_reg[C5];
   assign coin_lost = lost_reg;

endmodule

// File: tb/tb_coin_frontend.sv
// Bench for coin_frontend: three instances (gap 1, 200, 0) driven with directed
// and random sensor waveforms, compared each cycle against a window-based model.
module tb_coin_frontend;

   localparam int D  = 16;
   localparam int NI = 3;
   localparam int GAPS [NI] = '{1, 200, 0};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] rv [NI];
   wire  [3:0] o0;
   wire  [3:0] o1;
   wire  [3:0] o2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   coin_frontend #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(1)) u_gap1 (
      .clk(clk), .rst_n(rst_n),
      .raw_c1(rv[0][0]), .raw_c2(rv[0][1]), .raw_c5(rv[0][2]),
      .in1(o0[0]), .in2(o0[1]), .in5(o0[2]), .coin_lost(o0[3])
   );

   coin_frontend #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(200)) u_gap200 (
      .clk(clk), .rst_n(rst_n),
      .raw_c1(rv[1][0]), .raw_c2(rv[1][1]), .raw_c5(rv[1][2]),
      .in1(o1[0]), .in2(o1[1]), .in5(o1[2]), .coin_lost(o1[3])
   );

   coin_frontend #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(0)) u_gap0 (
      .clk(clk), .rst_n(rst_n),
      .raw_c1(rv[2][0]), .raw_c2(rv[2][1]), .raw_c5(rv[2][2]),
      .in1(o2[0]), .in2(o2[1]), .in5(o2[2]), .coin_lost(o2[3])
   );

   // Reference model state: raw sample history, stable levels, pending coins,
   // and the earliest edge at which each arbiter may issue again.
   bit         hist [NI][3][D+2];
   bit         stab [NI][3];
   bit         pend [NI][3];
   int         next_free [NI];
   logic [3:0] exp_o [NI];
   int         n_edge = 0;

   function automatic logic [3:0] obs(int i);
      case (i)
         0:       return o0;
         1:       return o1;
         default: return o2;
      endcase
   endfunction

   task automatic check_val(string tag, int got, int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < D + 2; k++) hist[i][ch][k] = 1'b0;
            stab[i][ch] = 1'b0;
            pend[i][ch] = 1'b0;
         end
         next_free[i] = 0;
         exp_o[i]     = 4'b0000;
      end
   endtask

   // A level is accepted once the last D synchronised samples (raw delayed by
   // two edges) all disagree with the current stable level.
   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         bit rise [3];
         bit clr  [3];
         bit lost_any;
         int g;
         lost_any = 1'b0;
         g        = -1;
         for (int ch = 0; ch < 3; ch++) begin
            bit all_diff;
            for (int k = D + 1; k > 0; k--) hist[i][ch][k] = hist[i][ch][k-1];
            hist[i][ch][0] = rv[i][ch];
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
               if (hist[i][ch][k] == stab[i][ch]) all_diff = 1'b0;
            end
            rise[ch] = 1'b0;
            clr[ch]  = 1'b0;
            if (all_diff) begin
               stab[i][ch] = ~stab[i][ch];
               rise[ch]    = stab[i][ch];
            end
         end
         if (n_edge >= next_free[i]) begin
            for (int p = 2; p >= 0; p--) begin
               if (pend[i][p] && g < 0) g = p;
            end
         end
         if (g >= 0) begin
            clr[g]       = 1'b1;
            next_free[i] = n_edge + GAPS[i] + 1;
         end
         for (int ch = 0; ch < 3; ch++) begin
            if (rise[ch] && pend[i][ch] && !clr[ch]) lost_any = 1'b1;
            pend[i][ch] = (pend[i][ch] && !clr[ch]) || rise[ch];
         end
         exp_o[i] = {lost_any, g == 2, g == 1, g == 0};
      end
   endtask

   // Called at a negedge: compare, then advance one clock edge.
   task automatic step();
      for (int i = 0; i < NI; i++) begin
         logic [3:0] got;
         got = obs(i);
         check_val($sformatf("out_i%0d_e%0d", i, n_edge), int'(got), int'(exp_o[i]));
         check_val($sformatf("onehot_i%0d_e%0d", i, n_edge),
                   int'($countones(got[2:0]) <= 1), 1);
         if (got != 4'b0000) begin
            $display("txn inst=%0d edge=%0d in5=%0b in2=%0b in1=%0b coin_lost=%0b",
                     i, n_edge, got[2], got[1], got[0], got[3]);
         end
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      n_edge++;
      @(negedge clk);
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic set_all(logic [2:0] v);
      for (int i = 0; i < NI; i++) rv[i] = v;
   endtask

   initial begin
      rst_n = 1'b0;
      set_all(3'b000);
      model_reset();
      @(negedge clk);
      run(3);
      rst_n = 1'b1;
      run(5);

      // Single clean 2-coin.
      set_all(3'b010); run(40);
      set_all(3'b000); run(40);

      // Bouncing 1-coin line, then a clean hold.
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < NI; i++) rv[i][0] = ~rv[i][0];
         run(5);
      end
      set_all(3'b001); run(40);
      set_all(3'b000); run(60);

      // All three coins together; let the long-gap instance drain.
      set_all(3'b111); run(40);
      set_all(3'b000); run(650);

      // A 1-coin opens a gap, then two 5-coins arrive before it ends.
      set_all(3'b001); run(25);
      set_all(3'b000); run(5);
      set_all(3'b100); run(25);
      set_all(3'b000); run(25);
      set_all(3'b100); run(25);
      set_all(3'b000); run(450);

      // Random levels with random hold times, independently per line.
      for (int seg = 0; seg < 60; seg++) begin
         for (int i = 0; i < NI; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
               if ($urandom_range(0, 2) == 0) rv[i][ch] = ~rv[i][ch];
            end
         end
         run($urandom_range(2, 45));
      end
      set_all(3'b000); run(50);

      // Reset while 2- and 1-coins are pending.
      set_all(3'b011); run(20);
      set_all(3'b000); run(3);
      rst_n = 1'b0;
      model_reset();
      run(3);
      rst_n = 1'b1;
      run(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
